// File: rtl/wbu_pkg.sv
// Shared constants and helpers for the writeback unit and its scoreboard.
package wbu_pkg;
   localparam int REG_NUM   = 16;
   localparam int CPU_WIDTH = 32;
   localparam int REG_AW    = 5;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_EXU,
      SRC_LSU
   } wb_src_e;

   // A register address names real architectural state only if it is non-zero and in range.
   function automatic logic rd_live(input logic [REG_AW-1:0] rd, input int reg_num);
      return (rd != '0) && (int'(rd) < reg_num);
   endfunction
endpackage

// File: rtl/wbu_sb.sv
// Busy-register scoreboard: one set port (issue), one clear port (writeback), three query ports.
module wbu_sb
   import wbu_pkg::*;
#(
   parameter int REG_NUM = wbu_pkg::REG_NUM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_set_en,
   input  logic [REG_AW-1:0] i_set_addr,
   input  logic              i_clr_en,
   input  logic [REG_AW-1:0] i_clr_addr,
   input  logic [REG_AW-1:0] i_q1_addr,
   input  logic [REG_AW-1:0] i_q2_addr,
   input  logic [REG_AW-1:0] i_q3_addr,
   output logic              o_q1_busy,
   output logic              o_q2_busy,
   output logic              o_q3_busy
);
   localparam int IW = $clog2(REG_NUM);

   logic [REG_NUM-1:0] r_busy;
   logic               w_set_live;
   logic               w_clr_live;

   assign w_set_live = i_set_en & rd_live(i_set_addr, REG_NUM);
   assign w_clr_live = i_clr_en & rd_live(i_clr_addr, REG_NUM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         if (w_clr_live) r_busy[i_clr_addr[IW-1:0]] <= 1'b0;
         if (w_set_live) r_busy[i_set_addr[IW-1:0]] <= 1'b1;
      end
   end

   assign o_q1_busy = rd_live(i_q1_addr, REG_NUM) & r_busy[i_q1_addr[IW-1:0]];
   assign o_q2_busy = rd_live(i_q2_addr, REG_NUM) & r_busy[i_q2_addr[IW-1:0]];
   assign o_q3_busy = rd_live(i_q3_addr, REG_NUM) & r_busy[i_q3_addr[IW-1:0]];
endmodule

// File: rtl/wbu.sv
// Writeback unit: arbitrates EXU/LSU results into a registered regfile write stage
// and owns the busy scoreboard used by decode for RAW stalls and WAW blocking.
module wbu
   import wbu_pkg::*;
#(
   parameter int REG_NUM   = wbu_pkg::REG_NUM,
   parameter int CPU_WIDTH = wbu_pkg::CPU_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iss_valid,
   input  logic [REG_AW-1:0]    iss_rd,
   output logic                 iss_ready,
   input  logic                 exu_valid,
   output logic                 exu_ready,
   input  logic [REG_AW-1:0]    exu_rd,
   input  logic [CPU_WIDTH-1:0] exu_data,
   input  logic                 lsu_valid,
   output logic                 lsu_ready,
   input  logic [REG_AW-1:0]    lsu_rd,
   input  logic [CPU_WIDTH-1:0] lsu_data,
   input  logic [REG_AW-1:0]    rs1_addr,
   input  logic [REG_AW-1:0]    rs2_addr,
   output logic                 rs1_busy,
   output logic                 rs2_busy,
   output logic                 rf_en,
   output logic [REG_AW-1:0]    rf_waddr,
   output logic [CPU_WIDTH-1:0] rf_wdata,
   output logic [31:0]          wb_cnt
);
   wb_src_e              w_src;
   logic                 w_fire;
   logic [REG_AW-1:0]    w_rd;
   logic [CPU_WIDTH-1:0] w_data;
   logic                 w_iss_busy;
   logic                 w_q1_busy;
   logic                 w_q2_busy;
   logic                 r_rf_en;
   logic [REG_AW-1:0]    r_rf_waddr;
   logic [CPU_WIDTH-1:0] r_rf_wdata;
   logic [31:0]          r_wb_cnt;

   // LSU has fixed priority; EXU is held off whenever a load result is presented.
   always_comb begin
      w_src  = SRC_NONE;
      w_rd   = '0;
      w_data = '0;
      if (lsu_valid) begin
         w_src  = SRC_LSU;
         w_rd   = lsu_rd;
         w_data = lsu_data;
      end else if (exu_valid) begin
         w_src  = SRC_EXU;
         w_rd   = exu_rd;
         w_data = exu_data;
      end
   end

   assign w_fire    = (w_src != SRC_NONE);
   assign lsu_ready = 1'b1;
   assign exu_ready = ~lsu_valid;
   assign iss_ready = ~iss_valid | ~w_iss_busy;

   wbu_sb #(.REG_NUM(REG_NUM)) u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_set_en   (iss_valid & iss_ready),
      .i_set_addr (iss_rd),
      .i_clr_en   (w_fire),
      .i_clr_addr (w_rd),
      .i_q1_addr  (rs1_addr),
      .i_q2_addr  (rs2_addr),
      .i_q3_addr  (iss_rd),
      .o_q1_busy  (w_q1_busy),
      .o_q2_busy  (w_q2_busy),
      .o_q3_busy  (w_iss_busy)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rf_en    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_wb_cnt   <= '0;
      end else begin
         r_rf_en  <= w_fire & rd_live(w_rd, REG_NUM);
         r_wb_cnt <= r_wb_cnt + {31'd0, r_rf_en};
         if (w_fire) begin
            r_rf_waddr <= w_rd;
            r_rf_wdata <= w_data;
         end
      end
   end

   // The write stage counts as busy until the regfile has actually taken the value.
   assign rs1_busy = rd_live(rs1_addr, REG_NUM) & (w_q1_busy | (r_rf_en & (r_rf_waddr == rs1_addr)));
   assign rs2_busy = rd_live(rs2_addr, REG_NUM) & (w_q2_busy | (r_rf_en & (r_rf_waddr == rs2_addr)));

   assign rf_en    = r_rf_en;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;
   assign wb_cnt   = r_wb_cnt;
endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: per-cycle vector table with a write scoreboard,
// plus hand-written reset-mid-stream and counter-wrap sequences.
module tb_wbu;
   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic        exu_valid;
   logic        exu_ready;
   logic [4:0]  exu_rd;
   logic [31:0] exu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rf_en;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] wb_cnt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];
   logic [31:0] exp_cnt = 32'd0;

   typedef struct {
      logic        iv;
      logic [4:0]  ird;
      logic        ev;
      logic [4:0]  erd;
      logic [31:0] ed;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        x_iss_ready;
      logic        x_exu_ready;
      logic        x_rs1_busy;
      logic        x_rs2_busy;
   } vec_t;
   vec_t vecs[17];

   always #5 clk = ~clk;

   wbu dut (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_ready (iss_ready),
      .exu_valid (exu_valid),
      .exu_ready (exu_ready),
      .exu_rd    (exu_rd),
      .exu_data  (exu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy),
      .rf_en     (rf_en),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .wb_cnt    (wb_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic live(input logic [4:0] rd);
      return (rd >= 5'd1) && (rd <= 5'd15);
   endfunction

   function automatic vec_t mk(input logic iv, input logic [4:0] ird,
                               input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic xir, input logic xer, input logic xb1, input logic xb2);
      vec_t v;
      v.iv = iv; v.ird = ird; v.ev = ev; v.erd = erd; v.ed = ed;
      v.lv = lv; v.lrd = lrd; v.ld = ld; v.r1 = r1; v.r2 = r2;
      v.x_iss_ready = xir; v.x_exu_ready = xer; v.x_rs1_busy = xb1; v.x_rs2_busy = xb2;
      return v;
   endfunction

   // Scoreboard consumer: every regfile write must match the oldest expected write.
   always @(negedge clk) begin
      if (rst === 1'b0 && rf_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr %0d data %h want no write", rf_waddr, rf_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {27'd0, rf_waddr}, {27'd0, e.rd});
            chk("wr_data", rf_wdata, e.data);
         end
      end
   end

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      iss_valid = v.iv; iss_rd = v.ird;
      exu_valid = v.ev; exu_rd = v.erd; exu_data = v.ed;
      lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
      rs1_addr = v.r1; rs2_addr = v.r2;
      #1;
      chk({tag, "_iss_ready"}, {31'd0, iss_ready}, {31'd0, v.x_iss_ready});
      chk({tag, "_exu_ready"}, {31'd0, exu_ready}, {31'd0, v.x_exu_ready});
      chk({tag, "_lsu_ready"}, {31'd0, lsu_ready}, 32'd1);
      chk({tag, "_rs1_busy"},  {31'd0, rs1_busy},  {31'd0, v.x_rs1_busy});
      chk({tag, "_rs2_busy"},  {31'd0, rs2_busy},  {31'd0, v.x_rs2_busy});
      if (v.lv) begin
         if (live(v.lrd)) begin
            exp_q.push_back('{rd: v.lrd, data: v.ld});
            exp_cnt++;
         end
      end else if (v.ev && live(v.erd)) begin
         exp_q.push_back('{rd: v.erd, data: v.ed});
         exp_cnt++;
      end
   endtask

   initial begin
      rst = 1'b1;
      iss_valid = 0; iss_rd = 0; exu_valid = 0; exu_rd = 0; exu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0; rs1_addr = 0; rs2_addr = 0;

      //               iv ird  ev erd ed            lv lrd ld     r1  r2  ir er b1 b2
      vecs[0]  = mk(1, 3,  0, 0, 32'h0,        0, 0, 32'h0,  3,  0,  1, 1, 0, 0);
      vecs[1]  = mk(0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  3,  5,  1, 1, 1, 0);
      vecs[2]  = mk(1, 5,  0, 0, 32'h0,        0, 0, 32'h0,  3,  5,  1, 1, 1, 0);
      vecs[3]  = mk(1, 3,  0, 0, 32'h0,        0, 0, 32'h0,  5,  3,  0, 1, 1, 1);
      vecs[4]  = mk(1, 3,  1, 3, 32'hDEADBEEF, 0, 0, 32'h0,  3,  5,  0, 1, 1, 1);
      vecs[5]  = mk(1, 3,  0, 0, 32'h0,        0, 0, 32'h0,  3,  5,  1, 1, 1, 1);
      vecs[6]  = mk(0, 0,  1, 5, 32'h55,       1, 3, 32'h33, 3,  5,  1, 0, 1, 1);
      vecs[7]  = mk(0, 0,  1, 5, 32'h55,       0, 0, 32'h0,  3,  5,  1, 1, 1, 1);
      vecs[8]  = mk(0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  3,  5,  1, 1, 0, 1);
      vecs[9]  = mk(0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  3,  5,  1, 1, 0, 0);
      vecs[10] = mk(1, 0,  1, 0, 32'h1234,     0, 0, 32'h0,  0,  0,  1, 1, 0, 0);
      vecs[11] = mk(1, 20, 0, 0, 32'h0,        0, 0, 32'h0,  20, 4,  1, 1, 0, 0);
      vecs[12] = mk(1, 4,  0, 0, 32'h0,        1, 9, 32'h99, 9,  4,  1, 0, 0, 0);
      vecs[13] = mk(0, 0,  1, 6, 32'h66,       1, 4, 32'h44, 9,  4,  1, 0, 1, 1);
      vecs[14] = mk(0, 0,  1, 6, 32'h66,       0, 0, 32'h0,  9,  4,  1, 1, 0, 1);
      vecs[15] = mk(0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  6,  4,  1, 1, 1, 0);
      vecs[16] = mk(0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  6,  0,  1, 1, 0, 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rf_en",    {31'd0, rf_en}, 32'd0);
      chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_wb_cnt",   wb_cnt, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) apply(vecs[i], $sformatf("row%0d", i));
      chk("table_wb_cnt", wb_cnt, exp_cnt);
      chk("table_rf_en_idle", {31'd0, rf_en}, 32'd0);

      // Reset asserted mid-cycle while x5 is busy and a write to x2 is in the write stage.
      apply(mk(1, 5, 1, 2, 32'h22, 0, 0, 32'h0, 5, 2, 1, 1, 0, 0), "pre_rst");
      @(posedge clk);
      #2;
      iss_valid = 1; iss_rd = 5; exu_valid = 0; rs1_addr = 5; rs2_addr = 2;
      #1;
      chk("mid_rs1_busy",  {31'd0, rs1_busy}, 32'd1);
      chk("mid_rs2_busy",  {31'd0, rs2_busy}, 32'd1);
      chk("mid_iss_ready", {31'd0, iss_ready}, 32'd0);
      rst = 1'b1;
      exp_q.delete();
      exp_cnt = 32'd0;
      #1;
      chk("arst_rf_en",     {31'd0, rf_en}, 32'd0);
      chk("arst_rf_waddr",  {27'd0, rf_waddr}, 32'd0);
      chk("arst_rf_wdata",  rf_wdata, 32'd0);
      chk("arst_wb_cnt",    wb_cnt, 32'd0);
      chk("arst_rs1_busy",  {31'd0, rs1_busy}, 32'd0);
      chk("arst_rs2_busy",  {31'd0, rs2_busy}, 32'd0);
      chk("arst_iss_ready", {31'd0, iss_ready}, 32'd1);
      chk("arst_exu_ready", {31'd0, exu_ready}, 32'd1);
      @(negedge clk);
      iss_valid = 0;
      rst = 1'b0;
      apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 5, 2, 1, 1, 0, 0), "post_rst");

      // Counter wrap: preload near the top, then two back-to-back writes.
      @(negedge clk);
      dut.r_wb_cnt = 32'hFFFF_FFFE;
      exp_cnt = 32'hFFFF_FFFE;
      apply(mk(0, 0, 1, 1, 32'h1, 0, 0, 32'h0, 0, 0, 1, 1, 0, 0), "wrap_w1");
      apply(mk(0, 0, 1, 2, 32'h2, 0, 0, 32'h0, 1, 0, 1, 1, 1, 0), "wrap_w2");
      apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 2, 1, 1, 0, 1), "wrap_i1");
      chk("wrap_cnt_max", wb_cnt, 32'hFFFF_FFFF);
      apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 2, 1, 1, 0, 0), "wrap_i2");
      chk("wrap_cnt_zero", wb_cnt, 32'd0);

      @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
